// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg
//   Shared definitions for the RTC bus responder: FSM state enumeration,
//   strobe idle level, AD bus width and the ad-pin phase encoding.
//   Also provides small edge-detect helpers used by the responder.
package rtc_bus_pkg;

    // Width of the multiplexed AD bus.
    localparam int unsigned BUS_W = 8;

    // Active-low strobes (rd, cs, wr) rest at this level.
    localparam logic STROBE_IDLE = 1'b1;

    // Meaning of the ad select pin.
    localparam logic AD_ADDR_PHASE = 1'b0;
    localparam logic AD_DATA_PHASE = 1'b1;

    // Responder FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_ERROR
    } rtc_state_e;

    // Rising/falling edge of a synchronized signal against its delayed copy.
    function automatic logic f_rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

    function automatic logic f_fall(input logic cur, input logic prev);
        return ~cur & prev;
    endfunction

endpackage

// File: rtl/rtc_bus_sync.sv
// rtc_bus_sync
//   Multi-stage flop synchronizer for a bundle of asynchronous inputs.
//   Every bit goes through the same number of stages, so a data bus
//   carried in the bundle stays aligned with its strobes.
// Ports:
//   clk      in   clock of the destination domain
//   reset_n  in   asynchronous active-low reset (stages preset to RESET_VAL)
//   i_d      in   WIDTH  asynchronous input bundle
//   o_q      out  WIDTH  synchronized bundle (STAGES cycles later)
module rtc_bus_sync #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Stage 0 is the capture flop; stage STAGES-1 is the output.
    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= {STAGES{RESET_VAL}};
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
//   RTC-side responder of the multiplexed address/data bus. Decodes the
//   active-low ad/rd/cs/wr strobes (after synchronization), latches the
//   register address, commits write data into an internal register file
//   and drives read data back onto the AD bus.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   ad         in   address/data select (0 = address, 1 = data)
//   rd         in   read strobe, active-low
//   cs         in   chip select, active-low
//   wr         in   write strobe, active-low
//   ad_in      in   8  AD bus value driven by the initiator
//   ad_out     out  8  AD bus value driven by this block (registered)
//   ad_oe      out  1 = this block drives the AD bus (registered)
//   wr_pulse   out  one-cycle pulse when a write commits
//   wr_addr    out  8  address of the last committed write
//   wr_data    out  8  data of the last committed write
//   proto_err  out  one-cycle pulse on a protocol violation
//   cur_addr   out  8  currently latched address
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ad,
    input  logic             rd,
    input  logic             cs,
    input  logic             wr,
    input  logic [BUS_W-1:0] ad_in,
    output logic [BUS_W-1:0] ad_out,
    output logic             ad_oe,
    output logic             wr_pulse,
    output logic [BUS_W-1:0] wr_addr,
    output logic [BUS_W-1:0] wr_data,
    output logic             proto_err,
    output logic [BUS_W-1:0] cur_addr
);

    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned SYNC_W = 4 + BUS_W;
    localparam logic [SYNC_W-1:0] SYNC_PRESET =
        {AD_DATA_PHASE, STROBE_IDLE, STROBE_IDLE, STROBE_IDLE, {BUS_W{1'b0}}};

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_W-1:0] w_sync_in;
    logic [SYNC_W-1:0] w_sync_out;
    logic              w_s_ad;
    logic              w_s_rd;
    logic              w_s_cs;
    logic              w_s_wr;
    logic [BUS_W-1:0]  w_s_adin;

    assign w_sync_in = {ad, rd, cs, wr, ad_in};

    rtc_bus_sync #(
        .WIDTH     (SYNC_W),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (SYNC_PRESET)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (w_sync_in),
        .o_q     (w_sync_out)
    );

    assign {w_s_ad, w_s_rd, w_s_cs, w_s_wr, w_s_adin} = w_sync_out;

    // One-cycle-delayed copies for edge detection. r_p_adin is the data
    // seen the cycle before a wr rising edge, which is what gets committed.
    logic             r_p_rd;
    logic             r_p_cs;
    logic             r_p_wr;
    logic [BUS_W-1:0] r_p_adin;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p_rd   <= STROBE_IDLE;
            r_p_cs   <= STROBE_IDLE;
            r_p_wr   <= STROBE_IDLE;
            r_p_adin <= '0;
        end else begin
            r_p_rd   <= w_s_rd;
            r_p_cs   <= w_s_cs;
            r_p_wr   <= w_s_wr;
            r_p_adin <= w_s_adin;
        end
    end

    logic w_wr_rise;
    logic w_wr_fall;
    logic w_rd_rise;
    logic w_rd_fall;
    logic w_cs_rise;

    assign w_wr_rise = f_rise(w_s_wr, r_p_wr);
    assign w_wr_fall = f_fall(w_s_wr, r_p_wr);
    assign w_rd_rise = f_rise(w_s_rd, r_p_rd);
    assign w_rd_fall = f_fall(w_s_rd, r_p_rd);
    assign w_cs_rise = f_rise(w_s_cs, r_p_cs);

    // ------------------------------------------------------------------
    // Register file and address state
    // ------------------------------------------------------------------
    logic [BUS_W-1:0] r_regs [NUM_REGS];
    logic [BUS_W-1:0] r_cur_addr;
    logic             w_in_range;
    logic [BUS_W-1:0] w_rdata;

    assign w_in_range = ({1'b0, r_cur_addr} < 9'(NUM_REGS));
    assign w_rdata    = w_in_range ? r_regs[r_cur_addr[IDX_W-1:0]] : '0;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    rtc_state_e r_state;
    rtc_state_e w_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_s_cs && !w_s_wr && w_s_rd) begin
                    w_next = (w_s_ad == AD_ADDR_PHASE) ? ST_ADDR : ST_WDATA;
                end else if (!w_s_cs && !w_s_rd && w_s_wr && (w_s_ad == AD_DATA_PHASE)) begin
                    w_next = ST_RDATA;
                end else if ((!w_s_rd && !w_s_wr && !w_s_cs) ||
                             (!w_s_rd && (w_s_ad == AD_ADDR_PHASE))) begin
                    w_next = ST_ERROR;
                end
            end
            // A wr edge wins over a simultaneous cs rise, so cs and wr
            // released together still complete the access.
            ST_ADDR, ST_WDATA: begin
                if (w_wr_rise) begin
                    w_next = ST_IDLE;
                end else if (w_rd_fall) begin
                    w_next = ST_ERROR;
                end else if (w_cs_rise) begin
                    w_next = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (w_wr_fall) begin
                    w_next = ST_ERROR;
                end else if (w_rd_rise || w_cs_rise) begin
                    w_next = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (w_s_rd && w_s_wr) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    logic             w_latch_addr;
    logic             w_commit;
    logic             w_oe_nxt;
    logic [BUS_W-1:0] w_out_nxt;
    logic             w_err_nxt;

    always_comb begin
        w_latch_addr = (r_state == ST_ADDR) && w_wr_rise;
        w_commit     = (r_state == ST_WDATA) && w_wr_rise && w_in_range;
        w_oe_nxt     = (w_next == ST_RDATA);
        w_out_nxt    = w_oe_nxt ? w_rdata : '0;
        w_err_nxt    = (w_next == ST_ERROR) && (r_state != ST_ERROR);
    end

    // ------------------------------------------------------------------
    // Registered datapath and outputs
    // ------------------------------------------------------------------
    logic             r_ad_oe;
    logic [BUS_W-1:0] r_ad_out;
    logic             r_wr_pulse;
    logic [BUS_W-1:0] r_wr_addr;
    logic [BUS_W-1:0] r_wr_data;
    logic             r_proto_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_regs      <= '{default: '0};
            r_cur_addr  <= '0;
            r_ad_oe     <= 1'b0;
            r_ad_out    <= '0;
            r_wr_pulse  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_ad_oe     <= w_oe_nxt;
            r_ad_out    <= w_out_nxt;
            r_wr_pulse  <= w_commit;
            r_proto_err <= w_err_nxt;
            if (w_latch_addr) begin
                r_cur_addr <= r_p_adin;
            end
            if (w_commit) begin
                r_regs[r_cur_addr[IDX_W-1:0]] <= r_p_adin;
                r_wr_addr                     <= r_cur_addr;
                r_wr_data                     <= r_p_adin;
            end
        end
    end

    assign ad_out    = r_ad_out;
    assign ad_oe     = r_ad_oe;
    assign wr_pulse  = r_wr_pulse;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign proto_err = r_proto_err;
    assign cur_addr  = r_cur_addr;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder
//   Directed and randomized bus transactions against a simple register-file
//   model (array + current address). Checks reset state, write commit
//   latency and contents, read latency and data, out-of-range handling,
//   protocol errors, cs/wr simultaneous release and reset during a read.
module tb_rtc_bus_responder;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned SYNC     = 2;
    localparam int unsigned HOLD     = SYNC + 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ad = 1'b1;
    logic       rd = 1'b1;
    logic       cs = 1'b1;
    logic       wr = 1'b1;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       wr_pulse;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       proto_err;
    logic [7:0] cur_addr;

    rtc_bus_responder #(
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ad        (ad),
        .rd        (rd),
        .cs        (cs),
        .wr        (wr),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .proto_err (proto_err),
        .cur_addr  (cur_addr)
    );

    always #5 clk = ~clk;

    // Observed pulse counters (compared against model counts).
    int unsigned pulse_cnt = 0;
    int unsigned err_cnt   = 0;
    always @(posedge clk) begin
        if (wr_pulse)  pulse_cnt <= pulse_cnt + 1;
        if (proto_err) err_cnt   <= err_cnt + 1;
    end

    // Reference model
    logic [7:0]  m_regs [256];
    int unsigned m_cur    = 0;
    int unsigned m_pulses = 0;
    int unsigned m_errs   = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read();
        return (m_cur < NUM_REGS) ? m_regs[m_cur] : 8'h00;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
        m_cur = 0;
    endtask

    task automatic bus_addr(input logic [7:0] a);
        @(negedge clk);
        cs = 1'b0; ad = 1'b0; ad_in = a; wr = 1'b0;
        repeat (HOLD) @(negedge clk);
        wr = 1'b1;
        repeat (2) @(negedge clk);
        cs = 1'b1; ad_in = 8'($urandom);
        m_cur = a;
        repeat (HOLD) @(negedge clk);
        chk("cur_addr", cur_addr, a);
    endtask

    task automatic bus_write(input logic [7:0] d, input bit cs_with_wr);
        logic exp_pulse;
        exp_pulse = (m_cur < NUM_REGS);
        @(negedge clk);
        cs = 1'b0; ad = 1'b1; ad_in = d; wr = 1'b0;
        repeat (HOLD) @(negedge clk);
        wr = 1'b1;
        if (cs_with_wr) cs = 1'b1;
        repeat (SYNC) @(posedge clk);
        #1 chk("wr_pulse_early", wr_pulse, 1'b0);
        @(posedge clk);
        #1 chk("wr_pulse", wr_pulse, exp_pulse);
        if (exp_pulse) begin
            m_regs[m_cur] = d;
            m_pulses++;
            chk("wr_addr", wr_addr, m_cur[7:0]);
            chk("wr_data", wr_data, d);
        end
        @(posedge clk);
        #1 chk("wr_pulse_width", wr_pulse, 1'b0);
        @(negedge clk);
        cs = 1'b1; ad_in = 8'($urandom);
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic bus_read();
        logic [7:0] exp_d;
        exp_d = m_read();
        @(negedge clk);
        cs = 1'b0; ad = 1'b1; rd = 1'b0; ad_in = 8'($urandom);
        repeat (SYNC) @(posedge clk);
        #1 chk("ad_oe_early", ad_oe, 1'b0);
        @(posedge clk);
        #1 chk("ad_oe_on", ad_oe, 1'b1);
        chk("ad_out", ad_out, exp_d);
        @(negedge clk);
        repeat (HOLD - SYNC - 1) @(negedge clk);
        rd = 1'b1;
        repeat (SYNC) @(posedge clk);
        #1 chk("ad_out_hold", {ad_oe, ad_out}, {1'b1, exp_d});
        @(posedge clk);
        #1 chk("ad_oe_off", ad_oe, 1'b0);
        @(negedge clk);
        cs = 1'b1;
        repeat (HOLD) @(negedge clk);
    endtask

    // Watchdog: the directed sequence has no open-ended waits, but guard anyway.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();

        // Reset state
        #3;
        chk("rst_ad_oe", ad_oe, 1'b0);
        chk("rst_ad_out", ad_out, 8'h00);
        chk("rst_wr_pulse", wr_pulse, 1'b0);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_cur_addr", cur_addr, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic write then read
        bus_addr(8'h05);
        bus_write(8'hA7, 1'b0);
        bus_read();

        // Out-of-range address: no commit, reads zero
        bus_addr(8'h20);
        bus_write(8'h3C, 1'b0);
        bus_read();

        // Two data writes reuse the latched address
        bus_addr(8'h03);
        bus_write(8'h11, 1'b0);
        bus_write(8'h22, 1'b0);
        bus_read();
        chk("pulse_count_a", pulse_cnt, m_pulses);

        // Protocol violation: rd and wr low together with cs low
        @(negedge clk);
        cs = 1'b0; ad = 1'b1; rd = 1'b0; wr = 1'b0; ad_in = 8'hEE;
        repeat (SYNC) @(posedge clk);
        #1 chk("perr_early", proto_err, 1'b0);
        @(posedge clk);
        #1 chk("perr_pulse", {proto_err, ad_oe}, 2'b10);
        m_errs++;
        @(posedge clk);
        #1 chk("perr_width", proto_err, 1'b0);
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; cs = 1'b1;
        repeat (HOLD) @(negedge clk);
        chk("perr_no_commit", pulse_cnt, m_pulses);
        bus_read();                 // reg[3] still 0x22, and bus resumes

        // cs and wr released on the same clock still commits
        bus_addr(8'h07);
        bus_write(8'h5A, 1'b1);
        bus_read();

        // Randomized transactions
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       bus_addr(8'($urandom_range(0, 31)));
                1:       bus_write(8'($urandom), 1'($urandom_range(0, 1)));
                default: bus_read();
            endcase
        end
        chk("pulse_count_b", pulse_cnt, m_pulses);
        chk("perr_count", err_cnt, m_errs);

        // Reset during a read
        bus_addr(8'h05);
        bus_write(8'hC3, 1'b0);
        @(negedge clk);
        cs = 1'b0; ad = 1'b1; rd = 1'b0;
        repeat (SYNC + 1) @(posedge clk);
        #1 chk("mid_read_oe", ad_oe, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_read", {ad_oe, ad_out, cur_addr}, 17'h0);
        @(negedge clk);
        rd = 1'b1; cs = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        repeat (4) @(negedge clk);
        bus_addr(8'h05);
        bus_read();                 // cleared by reset

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
